// File: rtl/uart_tx_arbiter_if.sv
// Bus between the on-chip byte clients / uart_tx serializer side and the arbiter.
// The arbiter connects through the slave modport; the client/serializer side
// drives through the master modport.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_done;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_valid;
  logic                 uart_tx_ready;
  logic                 uart_tx_ack;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    output req_valid, req_data, req_last, uart_tx_ready, uart_tx_ack,
    input  req_ready, req_done, uart_tx_data, uart_tx_valid, grant_id, busy, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_ready, uart_tx_ack,
    output req_ready, req_done, uart_tx_data, uart_tx_valid, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte sources.
// One byte per grant; an ack watchdog aborts a byte if the serializer never acks.
// Optional packet lock: define UART_TX_ARB_LOCK_EN to keep the grant on one
// requester until a byte flagged req_last completes (or times out).
//
// state   | meaning
// S_ARB   | pick next requester, capture its byte
// S_ISSUE | uart_tx_valid pulse, watchdog cleared
// S_WAIT  | wait for uart_tx_ack or watchdog expiry
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave arb_bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_ARB   = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_rr_last;
  logic [ID_W-1:0]    r_grant;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found_hi, w_found_lo, w_found, w_take;
  logic [ID_W-1:0]    w_gnt_hi, w_gnt_lo, w_gnt;
  logic [NUM_REQ-1:0] w_ready;
  logic [7:0]         w_data;
  logic               w_last;

`ifdef UART_TX_ARB_LOCK_EN
  logic               r_lock_active;
  logic [ID_W-1:0]    r_lock_id;
  logic               r_cur_last;

  // While a packet is open only its owner is eligible.
  always_comb begin
    w_elig = arb_bus.req_valid;
    if (r_lock_active) begin
      w_elig = '0;
      w_elig[r_lock_id] = arb_bus.req_valid[r_lock_id];
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = w_last;

  // Every pending requester is eligible; req_last has no meaning here.
  always_comb begin
    w_elig = arb_bus.req_valid;
  end
`endif

  // Round-robin pick: lowest index above rr_last, else lowest index at/below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        if (i > int'(r_rr_last)) begin
          w_found_hi = 1'b1;
          w_gnt_hi   = ID_W'(i);
        end else begin
          w_found_lo = 1'b1;
          w_gnt_lo   = ID_W'(i);
        end
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_gnt   = w_found_hi ? w_gnt_hi : w_gnt_lo;
    w_take  = (r_state == S_ARB) && arb_bus.uart_tx_ready && w_found;
  end

  // One-hot accept strobe plus the winning requester's byte and last flag.
  always_comb begin
    w_ready = '0;
    w_data  = '0;
    w_last  = 1'b0;
    if (w_take) w_ready[w_gnt] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_data = arb_bus.req_data[i*8 +: 8];
        w_last = arb_bus.req_last[i];
      end
    end
  end

  // Arbitration FSM, registered serializer outputs and ack watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ARB;
      r_rr_last  <= ID_W'(NUM_REQ - 1);
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      r_lock_active <= 1'b0;
      r_lock_id     <= '0;
      r_cur_last    <= 1'b0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
      case (r_state)
        S_ARB: begin
          if (w_take) begin
            r_tx_data  <= w_data;
            r_grant    <= w_gnt;
            r_tx_valid <= 1'b1;
            r_state    <= S_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            r_cur_last <= w_last;
`endif
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (arb_bus.uart_tx_ack) begin
            r_done[r_grant] <= 1'b1;
            r_rr_last       <= r_grant;
            r_state         <= S_ARB;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock_active   <= ~r_cur_last;
            r_lock_id       <= r_grant;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_err     <= 1'b1;
            r_rr_last <= r_grant;
            r_state   <= S_ARB;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock_active <= 1'b0;
`endif
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_ARB;
      endcase
    end
  end

  assign arb_bus.req_ready     = w_ready;
  assign arb_bus.req_done      = r_done;
  assign arb_bus.uart_tx_data  = r_tx_data;
  assign arb_bus.uart_tx_valid = r_tx_valid;
  assign arb_bus.grant_id      = r_grant;
  assign arb_bus.busy          = (r_state != S_ARB);
  assign arb_bus.err_timeout   = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, fairness, backpressure,
// watchdog timeout, reset mid-byte and packet interleave (lock build aware).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arb_bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_valid     = '0;
    bus.req_last      = '0;
    bus.uart_tx_ack   = 1'b0;
    bus.uart_tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called just after a negedge; serves one byte end to end with a prompt ack.
  task automatic do_byte(input string tag, input int g, input logic [7:0] d, input bit drop);
    int n = 0;
    #1;
    while (bus.req_ready === '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << g));
    @(negedge clk);
    if (drop) bus.req_valid[g] = 1'b0;
    #1;
    chk({tag, "_txv"},  32'(bus.uart_tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.uart_tx_data), 32'(d));
    chk({tag, "_gid"},  32'(bus.grant_id), 32'(g));
    @(negedge clk);
    #1;
    chk({tag, "_txv0"}, 32'(bus.uart_tx_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.uart_tx_ack = 1'b1;
    @(negedge clk);
    bus.uart_tx_ack = 1'b0;
    #1;
    chk({tag, "_done"}, 32'(bus.req_done), 32'(1 << g));
  endtask

  initial begin
    int bad;
    int n0;
    int exp_g[4];
    logic [7:0] d;

    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_tx_ack   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", 32'({bus.req_ready, bus.req_done, bus.uart_tx_data, bus.uart_tx_valid,
                            bus.grant_id, bus.busy, bus.err_timeout}), 32'd0);

    // single byte from requester 2
    do_reset();
    bus.req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req_valid = 4'b0100;
    do_byte("single", 2, 8'hA5, 1'b1);
    @(negedge clk);
    #1;
    chk("single_done_pulse", 32'(bus.req_done), 32'd0);
    chk("single_idle", 32'(bus.busy), 32'd0);

    // fairness: all four streaming
    do_reset();
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i % 4);
      do_byte($sformatf("fair%0d", i), i % 4, d, 1'b0);
    end

    // backpressure, plus a stray ack while idle
    do_reset();
    bus.uart_tx_ready = 1'b0;
    bus.req_data      = {8'h00, 8'h00, 8'h5C, 8'h00};
    bus.req_valid     = 4'b0010;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.uart_tx_ack = (k == 1);
      #1;
      if (bus.req_ready !== '0 || bus.uart_tx_valid !== 1'b0 || bus.req_done !== '0 || bus.busy !== 1'b0)
        bad++;
      @(negedge clk);
    end
    bus.uart_tx_ack = 1'b0;
    chk("bp_hold", 32'(bad), 32'd0);
    bus.uart_tx_ready = 1'b1;
    do_byte("bp", 1, 8'h5C, 1'b1);

    // watchdog timeout on requester 0, requester 1 next
    do_reset();
    bus.req_data  = {8'h00, 8'h00, 8'h71, 8'h70};
    bus.req_valid = 4'b0011;
    #1;
    chk("to_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("to_txv", 32'(bus.uart_tx_valid), 32'd1);
    bad = 0;
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      @(negedge clk);
      #1;
      if (bus.err_timeout !== 1'b0 || bus.req_done !== '0 || bus.busy !== 1'b1) bad++;
    end
    chk("to_wait", 32'(bad), 32'd0);
    @(negedge clk);
    #1;
    chk("to_err", 32'(bus.err_timeout), 32'd1);
    chk("to_nodone", 32'(bus.req_done), 32'd0);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_next_pick", 32'(bus.req_ready), 32'b0010);
    bus.uart_tx_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("to_err_pulse", 32'(bus.err_timeout), 32'd0);
    bus.uart_tx_ready = 1'b1;
    do_byte("to_next", 1, 8'h71, 1'b1);

    // reset while waiting for ack
    do_reset();
    bus.req_data  = {8'h33, 8'h22, 8'h11, 8'h9E};
    bus.req_valid = 4'b0100;
    #1;
    chk("rw_ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_outputs", 32'({bus.req_ready, bus.req_done, bus.uart_tx_data, bus.uart_tx_valid,
                           bus.grant_id, bus.busy, bus.err_timeout}), 32'd0);
    bus.uart_tx_ack = 1'b1;
    repeat (2) @(negedge clk);
    bus.uart_tx_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rw_no_pulse", 32'({bus.req_done, bus.err_timeout, bus.busy}), 32'd0);
    bus.req_valid = 4'hF;
    do_byte("rw_next", 0, 8'h9E, 1'b0);

    // packet interleave vs lock
    do_reset();
`ifdef UART_TX_ARB_LOCK_EN
    exp_g = '{0, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    n0 = 0;
    bus.req_data  = {8'h00, 8'h00, 8'hD1, 8'hC0};
    bus.req_last  = 4'b0010;
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      d = (exp_g[i] == 0) ? 8'hC0 + 8'(n0) : 8'hD1;
      do_byte($sformatf("pkt%0d", i), exp_g[i], d, 1'b0);
      if (exp_g[i] == 0) begin
        n0++;
        bus.req_data[7:0] = 8'hC0 + 8'(n0);
        bus.req_last[0]   = (n0 == 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
